// File: rtl/fadd_s2_pipe.sv
// fadd_s2_pipe: multi-lane FP add second stage (round, pack, fflags) feeding a 2-entry
// output buffer and a sticky fflags accumulator. Optional flush-to-zero: FADD_S2_PIPE_FTZ_EN.
module fadd_s2_pipe #(
   parameter int EXPWIDTH  = 8,
   parameter int PRECISION = 24,
   parameter int LANES     = 4,
   parameter int TAGW      = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic [2:0]                       in_rm_i,
   input  logic [LANES-1:0]                 in_mask_i,
   input  logic [TAGW-1:0]                  in_tag_i,
   input  logic [LANES-1:0]                 in_far_sign_i,
   input  logic [LANES*EXPWIDTH-1:0]        in_far_exp_i,
   input  logic [LANES*(PRECISION+3)-1:0]   in_far_sig_i,
   input  logic [LANES-1:0]                 in_near_sign_i,
   input  logic [LANES*EXPWIDTH-1:0]        in_near_exp_i,
   input  logic [LANES*(PRECISION+3)-1:0]   in_near_sig_i,
   input  logic [LANES-1:0]                 in_near_sig_zero_i,
   input  logic [LANES-1:0]                 in_far_mul_of_i,
   input  logic [LANES-1:0]                 in_sel_far_i,
   input  logic [LANES-1:0]                 in_spc_valid_i,
   input  logic [LANES-1:0]                 in_spc_iv_i,
   input  logic [LANES-1:0]                 in_spc_nan_i,
   input  logic [LANES-1:0]                 in_spc_inf_sign_i,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic [LANES*(EXPWIDTH+PRECISION)-1:0] out_result_o,
   output logic [LANES*5-1:0]               out_fflags_o,
   output logic [TAGW-1:0]                  out_tag_o,
   input  logic                             acc_clr_i,
   output logic [4:0]                       acc_fflags_o
);
   localparam int SW = PRECISION + 3;
   localparam int FW = PRECISION - 1;
   localparam int RW = EXPWIDTH + PRECISION;
   localparam int BW = LANES*5 + LANES*RW + TAGW;
   localparam logic [EXPWIDTH-1:0] EMAX   = '1;
   localparam logic [EXPWIDTH-1:0] EMAXM1 = {{(EXPWIDTH-1){1'b1}}, 1'b0};
   localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

   // returns {cout, inexact, rounded fraction}
   function automatic logic [FW+1:0] rounding(input logic [FW-1:0] in, input logic rnd,
                                              input logic sticky, input logic sign,
                                              input logic [2:0] rm);
      logic up, inexact;
      logic [FW:0] sum;
      inexact = rnd | sticky;
      case (rm)
         RNE:     up = rnd & (sticky | in[0]);
         RTZ:     up = 1'b0;
         RDN:     up = inexact & sign;
         RUP:     up = inexact & ~sign;
         RMM:     up = rnd;
         default: up = 1'b0;
      endcase
      sum = {1'b0, in} + {{FW{1'b0}}, up};
      return {sum[FW], inexact, sum[FW-1:0]};
   endfunction

   // returns {fflags, packed result} for one lane
   function automatic logic [RW+4:0] lane_calc(
         input logic [2:0] rm, input logic mask,
         input logic fsign, input logic [EXPWIDTH-1:0] fexp, input logic [SW-1:0] fsig,
         input logic nsign, input logic [EXPWIDTH-1:0] nexp, input logic [SW-1:0] nsig,
         input logic nzero, input logic mul_of, input logic sel_far,
         input logic spc, input logic iv, input logic nan, input logic isign);
      logic [FW+1:0] fr, ftr, nr, ntr;
      logic [EXPWIDTH-1:0] fe, ne, rexp;
      logic [FW-1:0] rfrac;
      logic f_of, f_tiny, f_nx, f_uf, n_of, n_tiny, n_nx, n_uf, n_sign;
      logic sign, of, uf, nx, maxfin;
      logic [RW-1:0] res;
      logic [4:0] fl;
      fr  = rounding(fsig[PRECISION+1:3], fsig[2], |fsig[1:0], fsign, rm);
      ftr = rounding(fsig[PRECISION:2], fsig[1], fsig[0], fsign, rm);
      fe  = fexp + {{(EXPWIDTH-1){1'b0}}, fr[FW+1]};
      f_of   = (fexp == EMAX) | (fr[FW+1] & (fexp == EMAXM1)) | mul_of;
      f_tiny = (fsig[SW-1:SW-2] == 2'b00) | ((fsig[SW-1:SW-2] == 2'b01) & ~ftr[FW+1]);
      f_nx   = fr[FW] | f_of;
      f_uf   = f_tiny & f_nx & ~mul_of;

      n_sign = ((nexp == '0) & nzero) ? (rm == RDN) : nsign;
      nr  = rounding(nsig[PRECISION+1:3], nsig[2], |nsig[1:0], n_sign, rm);
      ntr = rounding(nsig[PRECISION:2], nsig[1], nsig[0], n_sign, rm);
      ne  = nexp + {{(EXPWIDTH-1){1'b0}}, nr[FW+1]};
      n_of   = (ne == EMAX);
      n_tiny = (nsig[SW-1:SW-2] == 2'b00) | ((nsig[SW-1:SW-2] == 2'b01) & ~ntr[FW+1]);
      n_nx   = nr[FW] | n_of;
      n_uf   = n_tiny & n_nx;

      if (sel_far) begin
         sign = fsign; of = f_of; uf = f_uf; nx = f_nx; rexp = fe; rfrac = fr[FW-1:0];
      end else begin
         sign = n_sign; of = n_of; uf = n_uf; nx = n_nx; rexp = ne; rfrac = nr[FW-1:0];
      end

      maxfin = (rm == RTZ) | ((rm == RDN) & ~sign) | ((rm == RUP) & sign);
      if (of)
         res = maxfin ? {sign, EMAXM1, {FW{1'b1}}} : {sign, EMAX, {FW{1'b0}}};
      else
         res = {sign, rexp, rfrac};
      fl = {2'b00, of, uf, nx};
`ifdef FADD_S2_PIPE_FTZ_EN
      if (!of && (rexp == '0) && (rfrac != '0)) begin
         res = {sign, {(RW-1){1'b0}}};
         fl[1:0] = 2'b11;
      end
`endif
      if (spc) begin
         res = nan ? {1'b0, EMAX, 1'b1, {(FW-1){1'b0}}} : {isign, EMAX, {FW{1'b0}}};
         fl  = {iv, 4'b0000};
      end
      if (!mask) begin
         res = '0;
         fl  = '0;
      end
      return {fl, res};
   endfunction

   logic [LANES*RW-1:0] lane_res;
   logic [LANES*5-1:0]  lane_fl;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign {lane_fl[l*5 +: 5], lane_res[l*RW +: RW]} = lane_calc(
         in_rm_i, in_mask_i[l],
         in_far_sign_i[l], in_far_exp_i[l*EXPWIDTH +: EXPWIDTH], in_far_sig_i[l*SW +: SW],
         in_near_sign_i[l], in_near_exp_i[l*EXPWIDTH +: EXPWIDTH], in_near_sig_i[l*SW +: SW],
         in_near_sig_zero_i[l], in_far_mul_of_i[l], in_sel_far_i[l],
         in_spc_valid_i[l], in_spc_iv_i[l], in_spc_nan_i[l], in_spc_inf_sign_i[l]);
   end

   // Stage boundary: rounded beats land in the 2-entry buffer
   logic [BW-1:0] mem [2];
   logic          head;
   logic [1:0]    count, count_nx;
   logic          ready_r;
   logic          push, pop, wr;
   logic [4:0]    or_fl;
   logic [4:0]    acc;

   assign push        = in_valid_i & ready_r;
   assign pop         = (count != 2'd0) & out_ready_i;
   assign wr          = head ^ (count == 2'd1);
   assign count_nx    = count + {1'b0, push} - {1'b0, pop};
   assign in_ready_o  = ready_r;
   assign out_valid_o = (count != 2'd0);
   assign {out_fflags_o, out_result_o, out_tag_o} = mem[head];
   assign acc_fflags_o = acc;

   always_comb begin
      or_fl = '0;
      for (int l = 0; l < LANES; l++) or_fl = or_fl | out_fflags_o[l*5 +: 5];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0]  <= '0;
         mem[1]  <= '0;
         head    <= 1'b0;
         count   <= 2'd0;
         ready_r <= 1'b1;
         acc     <= '0;
      end else begin
         if (push) mem[wr] <= {lane_fl, lane_res, in_tag_i};
         if (pop) head <= ~head;
         count   <= count_nx;
         ready_r <= (count_nx != 2'd2);
         if (pop)
            acc <= (acc_clr_i ? 5'd0 : acc) | or_fl;
         else if (acc_clr_i)
            acc <= '0;
      end
   end
endmodule

// File: tb/tb_fadd_s2_pipe.sv
// Directed testbench for fadd_s2_pipe: table of single-lane vectors plus hand-written
// sequences for reset, accumulator, backpressure ordering and mid-operation reset.
module tb_fadd_s2_pipe;
   localparam int L = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, acc_clr_i;
   logic [2:0] in_rm_i;
   logic [L-1:0] in_mask_i, in_far_sign_i, in_near_sign_i, in_near_sig_zero_i;
   logic [L-1:0] in_far_mul_of_i, in_sel_far_i, in_spc_valid_i, in_spc_iv_i;
   logic [L-1:0] in_spc_nan_i, in_spc_inf_sign_i;
   logic [7:0] in_tag_i, out_tag_o;
   logic [L*8-1:0] in_far_exp_i, in_near_exp_i;
   logic [L*27-1:0] in_far_sig_i, in_near_sig_i;
   logic [L*32-1:0] out_result_o;
   logic [L*5-1:0] out_fflags_o;
   logic [4:0] acc_fflags_o;

   fadd_s2_pipe dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_rm_i(in_rm_i), .in_mask_i(in_mask_i), .in_tag_i(in_tag_i),
      .in_far_sign_i(in_far_sign_i), .in_far_exp_i(in_far_exp_i), .in_far_sig_i(in_far_sig_i),
      .in_near_sign_i(in_near_sign_i), .in_near_exp_i(in_near_exp_i),
      .in_near_sig_i(in_near_sig_i), .in_near_sig_zero_i(in_near_sig_zero_i),
      .in_far_mul_of_i(in_far_mul_of_i), .in_sel_far_i(in_sel_far_i),
      .in_spc_valid_i(in_spc_valid_i), .in_spc_iv_i(in_spc_iv_i), .in_spc_nan_i(in_spc_nan_i),
      .in_spc_inf_sign_i(in_spc_inf_sign_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .out_result_o(out_result_o), .out_fflags_o(out_fflags_o),
      .out_tag_o(out_tag_o), .acc_clr_i(acc_clr_i), .acc_fflags_o(acc_fflags_o));

   always #5 clk = ~clk;

   localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
`ifdef FADD_S2_PIPE_FTZ_EN
   localparam logic [31:0] SUB1_RES = 32'h0000_0000;
   localparam logic [4:0]  SUB1_FL  = 5'h03;
   localparam logic [31:0] SUB2_RES = 32'h0000_0000;
   localparam logic [4:0]  SUB2_FL  = 5'h03;
`else
   localparam logic [31:0] SUB1_RES = 32'h0000_0001;
   localparam logic [4:0]  SUB1_FL  = 5'h03;
   localparam logic [31:0] SUB2_RES = 32'h0040_0000;
   localparam logic [4:0]  SUB2_FL  = 5'h00;
`endif

   typedef struct {
      int lane;
      logic [3:0] mask;
      logic [2:0] rm;
      logic sel_far, fsign, mul_of, nsign, nzero, spc, iv, nan, isign;
      logic [7:0] fexp, nexp;
      logic [26:0] fsig, nsig;
      logic [31:0] exp_res;
      logic [4:0] exp_fl;
   } vec_t;

   int n_vec = 0;
   int miss = 0;

   function automatic vec_t mk_base(int lane, logic [2:0] rm, logic [31:0] r, logic [4:0] f);
      vec_t v;
      v.lane = lane; v.mask = 4'(1 << lane); v.rm = rm;
      v.sel_far = 0; v.fsign = 0; v.mul_of = 0; v.nsign = 0; v.nzero = 0;
      v.spc = 0; v.iv = 0; v.nan = 0; v.isign = 0;
      v.fexp = 0; v.nexp = 0; v.fsig = 0; v.nsig = 0;
      v.exp_res = r; v.exp_fl = f;
      return v;
   endfunction

   function automatic vec_t mk_far(int lane, logic [2:0] rm, logic s, logic [7:0] e,
                                   logic [26:0] sig, logic mof, logic [31:0] r, logic [4:0] f);
      vec_t v = mk_base(lane, rm, r, f);
      v.sel_far = 1; v.fsign = s; v.fexp = e; v.fsig = sig; v.mul_of = mof;
      return v;
   endfunction

   function automatic vec_t mk_near(int lane, logic [2:0] rm, logic s, logic [7:0] e,
                                    logic [26:0] sig, logic z, logic [31:0] r, logic [4:0] f);
      vec_t v = mk_base(lane, rm, r, f);
      v.nsign = s; v.nexp = e; v.nsig = sig; v.nzero = z;
      return v;
   endfunction

   function automatic vec_t mk_spc(int lane, logic iv, logic nan, logic is,
                                   logic [31:0] r, logic [4:0] f);
      vec_t v = mk_base(lane, RNE, r, f);
      v.spc = 1; v.iv = iv; v.nan = nan; v.isign = is;
      return v;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_lanes();
      in_mask_i = 0; in_far_sign_i = 0; in_near_sign_i = 0; in_near_sig_zero_i = 0;
      in_far_mul_of_i = 0; in_sel_far_i = 0; in_spc_valid_i = 0; in_spc_iv_i = 0;
      in_spc_nan_i = 0; in_spc_inf_sign_i = 0; in_far_exp_i = 0; in_near_exp_i = 0;
      in_far_sig_i = 0; in_near_sig_i = 0;
   endtask

   task automatic put(input vec_t v);
      in_rm_i = v.rm;
      in_mask_i = in_mask_i | v.mask;
      in_sel_far_i[v.lane] = v.sel_far;
      in_far_sign_i[v.lane] = v.fsign;
      in_far_exp_i[v.lane*8 +: 8] = v.fexp;
      in_far_sig_i[v.lane*27 +: 27] = v.fsig;
      in_far_mul_of_i[v.lane] = v.mul_of;
      in_near_sign_i[v.lane] = v.nsign;
      in_near_exp_i[v.lane*8 +: 8] = v.nexp;
      in_near_sig_i[v.lane*27 +: 27] = v.nsig;
      in_near_sig_zero_i[v.lane] = v.nzero;
      in_spc_valid_i[v.lane] = v.spc;
      in_spc_iv_i[v.lane] = v.iv;
      in_spc_nan_i[v.lane] = v.nan;
      in_spc_inf_sign_i[v.lane] = v.isign;
   endtask

   task automatic load(input vec_t v, input logic [7:0] tag);
      clear_lanes();
      put(v);
      in_tag_i = tag;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[19];
   logic [7:0] exp_tags[3];
   int got;
   logic acc3;

   initial begin
      vecs[0]  = mk_spc(0, 1, 1, 0, 32'h7FC0_0000, 5'h10);
      vecs[1]  = mk_spc(1, 0, 0, 1, 32'hFF80_0000, 5'h00);
      vecs[2]  = mk_far(0, RNE, 0, 8'hFE, 27'h7FF_FFFF, 0, 32'h7F80_0000, 5'h05);
      vecs[3]  = mk_far(0, RTZ, 0, 8'hFE, 27'h7FF_FFFF, 0, 32'h7F7F_FFFF, 5'h01);
      vecs[4]  = mk_far(0, RTZ, 0, 8'hFF, 27'h7FF_FFFF, 0, 32'h7F7F_FFFF, 5'h05);
      vecs[5]  = mk_far(0, RDN, 1, 8'hFE, 27'h7FF_FFFF, 0, 32'hFF80_0000, 5'h05);
      vecs[6]  = mk_far(1, RUP, 1, 8'hFF, 27'h7FF_FFFF, 0, 32'hFF7F_FFFF, 5'h05);
      vecs[7]  = mk_near(0, RDN, 0, 8'h00, 27'h0, 1, 32'h8000_0000, 5'h00);
      vecs[8]  = mk_near(0, RNE, 0, 8'h00, 27'h0, 1, 32'h0000_0000, 5'h00);
      vecs[9]  = mk_far(0, RNE, 0, 8'h00, 27'h000_0009, 0, SUB1_RES, SUB1_FL);
      vecs[10] = mk_near(3, RNE, 0, 8'h7F, 27'h400_0000, 0, 32'h3F80_0000, 5'h00);
      vecs[11] = mk_far(2, RNE, 0, 8'h80, 27'h400_000C, 0, 32'h4000_0002, 5'h01);
      vecs[12] = mk_far(0, RMM, 0, 8'h80, 27'h400_0004, 0, 32'h4000_0001, 5'h01);
      vecs[13] = mk_far(0, RNE, 0, 8'h80, 27'h400_0004, 0, 32'h4000_0000, 5'h01);
      vecs[14] = mk_far(0, RNE, 0, 8'h10, 27'h400_0000, 1, 32'h7F80_0000, 5'h05);
      vecs[15] = mk_spc(2, 1, 1, 0, 32'h0, 5'h00);
      vecs[15].mask = 4'b0000;
      vecs[16] = mk_near(0, RNE, 0, 8'hFF, 27'h400_0000, 0, 32'h7F80_0000, 5'h05);
      vecs[17] = mk_near(1, RNE, 0, 8'h00, 27'h200_0000, 0, SUB2_RES, SUB2_FL);
      vecs[18] = mk_near(2, RDN, 1, 8'h7F, 27'h400_0001, 0, 32'hBF80_0001, 5'h01);

      in_valid_i = 0; out_ready_i = 1; acc_clr_i = 0; in_rm_i = RNE; in_tag_i = 0;
      clear_lanes();

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 0;
      tick();
      check("rst_out_valid", 128'(out_valid_o), 128'd0);
      check("rst_in_ready", 128'(in_ready_o), 128'd1);
      check("rst_acc", 128'(acc_fflags_o), 128'd0);
      check("rst_result", 128'(out_result_o), 128'd0);
      check("rst_tag", 128'(out_tag_o), 128'd0);

      // table-driven vectors, one beat per cycle
      for (int i = 0; i < 19; i++) begin
         load(vecs[i], 8'(i + 1));
         in_valid_i = 1;
         tick();
         in_valid_i = 0;
         check($sformatf("v%0d_valid", i), 128'(out_valid_o), 128'd1);
         check($sformatf("v%0d_result", i), 128'(out_result_o),
               128'(vecs[i].exp_res) << (vecs[i].lane * 32));
         check($sformatf("v%0d_fflags", i), 128'(out_fflags_o),
               128'(vecs[i].exp_fl) << (vecs[i].lane * 5));
         check($sformatf("v%0d_tag", i), 128'(out_tag_o), 128'(i + 1));
      end
      tick();
      tick();
      check("drained", 128'(out_valid_o), 128'd0);

      // accumulator: clear, accumulate across beats, clear-and-fire
      acc_clr_i = 1;
      tick();
      acc_clr_i = 0;
      check("acc_clear", 128'(acc_fflags_o), 128'd0);
      load(vecs[0], 8'h5A);
      put(vecs[1]);
      in_valid_i = 1;
      tick();
      in_valid_i = 0;
      check("two_lane_result", 128'(out_result_o), {64'd0, 32'hFF80_0000, 32'h7FC0_0000});
      check("two_lane_fflags", 128'(out_fflags_o), 128'h10);
      check("two_lane_tag", 128'(out_tag_o), 128'h5A);
      tick();
      check("acc_after_nv", 128'(acc_fflags_o), 128'h10);
      load(vecs[3], 8'h21);
      in_valid_i = 1;
      tick();
      in_valid_i = 0;
      tick();
      check("acc_or", 128'(acc_fflags_o), 128'h11);
      load(vecs[2], 8'h22);
      in_valid_i = 1;
      tick();
      in_valid_i = 0;
      acc_clr_i = 1;
      tick();
      acc_clr_i = 0;
      check("acc_clr_fire", 128'(acc_fflags_o), 128'h05);

      // backpressure: 3 beats offered, 2 accepted, release in order
      out_ready_i = 0;
      for (int t = 1; t <= 3; t++) begin
         load(vecs[10], 8'(t));
         in_valid_i = 1;
         check($sformatf("bp_ready%0d", t), 128'(in_ready_o), (t < 3) ? 128'd1 : 128'd0);
         if (t < 3) tick();
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("bp_hold_tag%0d", c), 128'(out_tag_o), 128'd1);
         check($sformatf("bp_hold_rdy%0d", c), 128'(in_ready_o), 128'd0);
      end
      exp_tags[0] = 8'd1; exp_tags[1] = 8'd2; exp_tags[2] = 8'd3;
      out_ready_i = 1;
      got = 0;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
         if (out_valid_o) begin
            check($sformatf("bp_order%0d", got), 128'(out_tag_o), 128'(exp_tags[got]));
            got++;
         end
         acc3 = in_valid_i && in_ready_o;
         tick();
         if (acc3) in_valid_i = 0;
      end
      if (got != 3) begin
         miss++;
         $display("FAIL bp_timeout: got %0d beats, expected 3", got);
      end
      tick();
      check("bp_empty", 128'(out_valid_o), 128'd0);

      // reset mid-operation drops buffered beats
      out_ready_i = 0;
      load(vecs[2], 8'h77);
      in_valid_i = 1;
      tick();
      tick();
      in_valid_i = 0;
      #3 rst = 1;
      #1;
      check("mid_rst_valid", 128'(out_valid_o), 128'd0);
      check("mid_rst_result", 128'(out_result_o), 128'd0);
      check("mid_rst_tag", 128'(out_tag_o), 128'd0);
      tick();
      rst = 0;
      out_ready_i = 1;
      tick();
      check("post_rst_ready", 128'(in_ready_o), 128'd1);
      check("post_rst_valid", 128'(out_valid_o), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miss);
      $finish;
   end
endmodule
